// File: rtl/bottle_fill_ctrl_if.sv
// Switch/sensor inputs and display/speaker outputs of the bottle fill sequencer.
// master = switch/sensor side, slave = the controller.
interface bottle_fill_ctrl_if;
    logic        isWork;
    logic        EN_set;
    logic [3:0]  set_high;
    logic [3:0]  set_low;
    logic        conti;
    logic        pill_pulse;
    logic        bottle_ready;
    logic        valve_open;
    logic        conveyor_step;
    logic [7:0]  target;
    logic [7:0]  pill_cnt;
    logic [11:0] bottle_cnt;
    logic        done_beep;
    logic [2:0]  state;

    modport master (
        output isWork, EN_set, set_high, set_low, conti, pill_pulse, bottle_ready,
        input  valve_open, conveyor_step, target, pill_cnt, bottle_cnt, done_beep, state
    );
    modport slave (
        input  isWork, EN_set, set_high, set_low, conti, pill_pulse, bottle_ready,
        output valve_open, conveyor_step, target, pill_cnt, bottle_cnt, done_beep, state
    );
endinterface

// File: rtl/bottle_fill_ctrl.sv
// Pill-bottling sequencer: BCD target latch, fill/pause/swap FSM, BCD pill and bottle tallies, beep timer.
// Optional batch stop (DONE state) enabled by defining BOTTLE_BATCH_EN.
module bottle_fill_ctrl #(
    parameter int          SWAP_CYCLES    = 8,
    parameter int          BEEP_CYCLES    = 16,
    parameter logic [7:0]  DEFAULT_TARGET = 8'h10
`ifdef BOTTLE_BATCH_EN
    , parameter logic [11:0] BATCH_SIZE   = 12'h010
`endif
) (
    input  logic              CLK_org,
    input  logic              RST,
    bottle_fill_ctrl_if.slave bus
);
    localparam int SWAP_W = $clog2(SWAP_CYCLES + 1);
    localparam int BEEP_W = $clog2(BEEP_CYCLES + 1);
    localparam logic [SWAP_W-1:0] SWAP_LAST = SWAP_W'(SWAP_CYCLES - 1);
    localparam logic [BEEP_W-1:0] BEEP_LOAD = BEEP_W'(BEEP_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_FILL  = 3'd2,
        S_PAUSE = 3'd3,
        S_SWAP  = 3'd4
`ifdef BOTTLE_BATCH_EN
        , S_DONE = 3'd5
`endif
    } state_e;

    state_e            state_q, state_d;
    logic [7:0]        target_q, target_d;
    logic [7:0]        pill_q, pill_d;
    logic [11:0]       bottle_q, bottle_d;
    logic [SWAP_W-1:0] swap_q, swap_d;
    logic [BEEP_W-1:0] beep_q, beep_d;
    logic              valve_q, valve_d;
    logic              conv_q, conv_d;
    logic              beep_out_q, beep_out_d;
    logic [7:0]        load_val, pill_inc;
    logic [11:0]       bottle_inc;

    function automatic logic [3:0] clamp9(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    function automatic logic [3:0] dig_inc(input logic [3:0] d);
        return (d == 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

    always_comb begin
        load_val   = {clamp9(bus.set_high), clamp9(bus.set_low)};
        pill_inc   = {(pill_q[3:0] == 4'd9) ? dig_inc(pill_q[7:4]) : pill_q[7:4], dig_inc(pill_q[3:0])};
        bottle_inc[3:0]  = dig_inc(bottle_q[3:0]);
        bottle_inc[7:4]  = (bottle_q[3:0] == 4'd9) ? dig_inc(bottle_q[7:4]) : bottle_q[7:4];
        bottle_inc[11:8] = (bottle_q[7:0] == 8'h99) ? dig_inc(bottle_q[11:8]) : bottle_q[11:8];

        state_d  = state_q;
        target_d = target_q;
        pill_d   = pill_q;
        bottle_d = bottle_q;
        swap_d   = swap_q;
        beep_d   = (beep_q != '0) ? beep_q - BEEP_W'(1) : beep_q;

        // Target load works in IDLE whether or not the line is enabled; all-zero target is rejected.
        if (state_q == S_IDLE && bus.EN_set && load_val != 8'h00)
            target_d = load_val;

        if (!bus.isWork) begin
            state_d = S_IDLE;
`ifdef BOTTLE_BATCH_EN
            if (state_q == S_DONE) bottle_d = '0;
`endif
        end else begin
            case (state_q)
                S_IDLE:  if (!bus.EN_set) state_d = S_WAIT;
                S_WAIT:  if (bus.bottle_ready) state_d = S_FILL;
                S_FILL: begin
                    if (bus.pill_pulse) pill_d = pill_inc;
                    // Target hit beats a pause request on the same cycle.
                    if (bus.pill_pulse && pill_inc == target_q) begin
                        bottle_d = bottle_inc;
                        beep_d   = BEEP_LOAD;
                        swap_d   = SWAP_LAST;
                        state_d  = S_SWAP;
`ifdef BOTTLE_BATCH_EN
                        if (bottle_inc == BATCH_SIZE) state_d = S_DONE;
`endif
                    end else if (bus.conti) begin
                        state_d = S_PAUSE;
                    end
                end
                S_PAUSE: if (!bus.conti) state_d = S_FILL;
                S_SWAP: begin
                    if (swap_q == '0) begin
                        pill_d  = '0;
                        state_d = S_WAIT;
                    end else begin
                        swap_d = swap_q - SWAP_W'(1);
                    end
                end
`ifdef BOTTLE_BATCH_EN
                S_DONE:  state_d = S_DONE;
`endif
                default: state_d = S_IDLE;
            endcase
        end

        valve_d    = (state_d == S_FILL);
        conv_d     = (state_d == S_SWAP);
`ifdef BOTTLE_BATCH_EN
        beep_out_d = (beep_d != '0) || (state_d == S_DONE);
`else
        beep_out_d = (beep_d != '0);
`endif
    end

    always_ff @(posedge CLK_org) begin
        if (RST) begin
            state_q    <= S_IDLE;
            target_q   <= DEFAULT_TARGET;
            pill_q     <= '0;
            bottle_q   <= '0;
            swap_q     <= '0;
            beep_q     <= '0;
            valve_q    <= 1'b0;
            conv_q     <= 1'b0;
            beep_out_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            pill_q     <= pill_d;
            bottle_q   <= bottle_d;
            swap_q     <= swap_d;
            beep_q     <= beep_d;
            valve_q    <= valve_d;
            conv_q     <= conv_d;
            beep_out_q <= beep_out_d;
        end
    end

    assign bus.valve_open    = valve_q;
    assign bus.conveyor_step = conv_q;
    assign bus.target        = target_q;
    assign bus.pill_cnt      = pill_q;
    assign bus.bottle_cnt    = bottle_q;
    assign bus.done_beep     = beep_out_q;
    assign bus.state         = state_q;
endmodule

// File: tb/tb_bottle_fill_ctrl.sv
// Directed bench for bottle_fill_ctrl; define BOTTLE_BATCH_EN to exercise the batch stop instead of tests 2-5.
module tb_bottle_fill_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   conv_n, beep_n;

    always #5 clk = ~clk;

    bottle_fill_ctrl_if bus ();

`ifdef BOTTLE_BATCH_EN
    bottle_fill_ctrl #(.SWAP_CYCLES(8), .BEEP_CYCLES(16), .DEFAULT_TARGET(8'h10), .BATCH_SIZE(12'h002))
        dut (.CLK_org(clk), .RST(rst), .bus(bus));
`else
    bottle_fill_ctrl #(.SWAP_CYCLES(8), .BEEP_CYCLES(16), .DEFAULT_TARGET(8'h10))
        dut (.CLK_org(clk), .RST(rst), .bus(bus));
`endif

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_target(input logic [3:0] hi, input logic [3:0] lo);
        bus.EN_set = 1'b1; bus.set_high = hi; bus.set_low = lo;
        tick();
        bus.EN_set = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.isWork = 1'b0; bus.EN_set = 1'b0; bus.set_high = '0; bus.set_low = '0;
        bus.conti = 1'b0; bus.pill_pulse = 1'b0; bus.bottle_ready = 1'b0;
        tick(3);
        rst = 1'b0;
        chk("rst_state", 32'(bus.state), 0);
        chk("rst_target", 32'(bus.target), 32'h10);
        chk("rst_pill", 32'(bus.pill_cnt), 0);
        chk("rst_bottle", 32'(bus.bottle_cnt), 0);
        chk("rst_outs", {bus.valve_open, bus.conveyor_step, bus.done_beep}, 0);

        // Target load, clamping, zero rejection
        set_target(4'h1, 4'h2); chk("t1_load12", 32'(bus.target), 32'h12);
        set_target(4'hA, 4'h0); chk("t1_clamp90", 32'(bus.target), 32'h90);
        set_target(4'h0, 4'h0); chk("t1_zero_rej", 32'(bus.target), 32'h90);

`ifdef BOTTLE_BATCH_EN
        set_target(4'h0, 4'h1);
        bus.isWork = 1'b1; bus.bottle_ready = 1'b1; bus.pill_pulse = 1'b1;
        for (int i = 0; i < 60 && bus.state !== 3'd5; i++) tick();
        chk("t6_done", 32'(bus.state), 5);
        chk("t6_bottle", 32'(bus.bottle_cnt), 32'h002);
        chk("t6_valve_conv", {bus.valve_open, bus.conveyor_step}, 0);
        beep_n = 0;
        for (int i = 0; i < 20; i++) begin tick(); if (bus.done_beep) beep_n++; end
        chk("t6_beep_steady", 32'(beep_n), 20);
        chk("t6_still_done", 32'(bus.state), 5);
        bus.isWork = 1'b0; tick();
        chk("t6_exit_idle", 32'(bus.state), 0);
        chk("t6_bottle_clr", 32'(bus.bottle_cnt), 0);
`else
        // Basic bottle with target 03
        set_target(4'h0, 4'h3);
        bus.isWork = 1'b1; bus.bottle_ready = 1'b1;
        tick(); chk("t2_wait", 32'(bus.state), 1);
        tick(); chk("t2_fill", 32'(bus.state), 2); chk("t2_valve_on", 32'(bus.valve_open), 1);
        bus.pill_pulse = 1'b1;
        tick(); chk("t2_p1", 32'(bus.pill_cnt), 32'h01);
        tick(); chk("t2_p2", 32'(bus.pill_cnt), 32'h02);
        tick(); chk("t2_p3", 32'(bus.pill_cnt), 32'h03);
        chk("t2_valve_off", 32'(bus.valve_open), 0);
        chk("t2_swap", 32'(bus.state), 4);
        chk("t2_bottle", 32'(bus.bottle_cnt), 32'h001);
        bus.bottle_ready = 1'b0;
        conv_n = bus.conveyor_step ? 1 : 0;
        beep_n = bus.done_beep ? 1 : 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.conveyor_step) conv_n++;
            if (bus.done_beep) beep_n++;
        end
        chk("t2_conv_len", 32'(conv_n), 8);
        chk("t2_beep_len", 32'(beep_n), 16);
        chk("t2_end_wait", 32'(bus.state), 1);
        chk("t2_pill_clr", 32'(bus.pill_cnt), 0);
        bus.pill_pulse = 1'b0;

        // BCD carry with target 12; pulses outside FILL ignored
        bus.isWork = 1'b0; tick();
        set_target(4'h1, 4'h2);
        bus.isWork = 1'b1; bus.bottle_ready = 1'b1;
        tick(2); chk("t3_fill", 32'(bus.state), 2);
        bus.bottle_ready = 1'b0; bus.pill_pulse = 1'b1;
        tick(9); chk("t3_p09", 32'(bus.pill_cnt), 32'h09);
        tick();  chk("t3_carry10", 32'(bus.pill_cnt), 32'h10);
        tick(2); chk("t3_swap", 32'(bus.state), 4);
        chk("t3_bottle", 32'(bus.bottle_cnt), 32'h002);
        tick(3); chk("t3_swap_hold", 32'(bus.pill_cnt), 32'h12);
        tick(5); chk("t3_wait", 32'(bus.state), 1);
        tick(2); chk("t3_wait_pill", 32'(bus.pill_cnt), 0);
        bus.pill_pulse = 1'b0;

        // Pause holds count and closes valve
        bus.bottle_ready = 1'b1; tick(); bus.bottle_ready = 1'b0;
        bus.pill_pulse = 1'b1; tick(5); bus.pill_pulse = 1'b0;
        chk("t4_p05", 32'(bus.pill_cnt), 32'h05);
        bus.conti = 1'b1; tick();
        chk("t4_pause", 32'(bus.state), 3);
        chk("t4_valve_off", 32'(bus.valve_open), 0);
        for (int i = 0; i < 4; i++) begin bus.pill_pulse = (i != 1); tick(); end
        bus.pill_pulse = 1'b0;
        chk("t4_pill_held", 32'(bus.pill_cnt), 32'h05);
        chk("t4_still_pause", 32'(bus.state), 3);
        bus.conti = 1'b0; tick();
        chk("t4_resume", {bus.state, bus.valve_open}, {3'd2, 1'b1});

        // isWork drop mid-FILL, resume partial bottle, then wrap tally 999 -> 000
        bus.isWork = 1'b0; tick();
        chk("t5_idle", 32'(bus.state), 0);
        chk("t5_pill_held", 32'(bus.pill_cnt), 32'h05);
        chk("t5_valve_off", 32'(bus.valve_open), 0);
        set_target(4'h0, 4'h6);
        bus.isWork = 1'b1; bus.bottle_ready = 1'b1;
        tick(2); bus.pill_pulse = 1'b1; tick();
        chk("t5_resume_hit", {bus.state, 1'b0, bus.pill_cnt, bus.bottle_cnt}, {3'd4, 1'b0, 8'h06, 12'h003});
        bus.bottle_ready = 1'b0; tick(8);
        bus.isWork = 1'b0; tick();
        set_target(4'h0, 4'h1);
        bus.isWork = 1'b1; bus.bottle_ready = 1'b1;
        for (int i = 0; i < 12000 && bus.bottle_cnt !== 12'h999; i++) tick();
        chk("t5_reach999", 32'(bus.bottle_cnt), 32'h999);
        for (int i = 0; i < 50 && bus.bottle_cnt !== 12'h000; i++) tick();
        chk("t5_wrap000", 32'(bus.bottle_cnt), 0);
        chk("t5_wrap_swap", 32'(bus.state), 4);
`endif

        // Reset mid-operation
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rst2_state", 32'(bus.state), 0);
        chk("rst2_target", 32'(bus.target), 32'h10);
        chk("rst2_cnts", {bus.pill_cnt, bus.bottle_cnt}, 0);
        chk("rst2_outs", {bus.valve_open, bus.conveyor_step, bus.done_beep}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
